cordic_result_fifo: RTL
=======================

CORDIC_RESULT_FIFO -- requirements
Module: cordic_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, with ports named Clk and Reset as in the rest of the codebase.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high; sampled on the rising edge of Clk.
REQ-005 data_in  input  1  one-cycle result strobe from the CORDIC core (its data_out).
REQ-006 X_in  input  16  CORDIC X result, valid while data_in=1.
REQ-007 Y_in  input  16  CORDIC Y result, valid while data_in=1.
REQ-008 rd_ready  input  1  consumer accepts the head entry this cycle.
REQ-009 clr_ovf  input  1  clears the sticky overflow flag.
REQ-010 out_valid  output  1  head entry present (count != 0).
REQ-011 X_out  output  16  head entry X value.
REQ-012 Y_out  output  16  head entry Y value.
REQ-013 full  output  1  count == DEPTH.
REQ-014 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-015 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-016 The block SHALL provide a first-word-fall-through FIFO of {X_in,Y_in} pairs: circular storage with read and write pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
REQ-017 A push SHALL occur on a Clk edge where data_in=1 and either full=0, or full=1 with a pop on the same edge.
REQ-018 A pop SHALL occur on a Clk edge where out_valid=1 and rd_ready=1; rd_ready while out_valid=0 SHALL have no effect.
REQ-019 Latency: a pair pushed at edge k SHALL appear on X_out/Y_out with out_valid=1 from edge k onward, provided the FIFO was empty before edge k; there SHALL be no same-cycle combinational bypass from X_in to X_out.
REQ-020 X_out/Y_out SHALL be 16'h0000 whenever out_valid=0, and otherwise SHALL equal the entry at the read pointer.
REQ-021 When a push and a pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance; this SHALL also hold when the FIFO is full.
REQ-022 A push alone SHALL increment count, and a pop alone SHALL decrement it; count SHALL never exceed DEPTH or go below 0.
REQ-023 When data_in=1, full=1 and no pop occurs, the input pair SHALL be discarded, storage SHALL be unchanged, and overflow SHALL be set at that edge.
REQ-024 overflow SHALL remain 1 until Reset, or until an edge with clr_ovf=1.
REQ-025 If a drop and clr_ovf=1 occur on the same edge, overflow SHALL be 1 after that edge (set wins).
REQ-026 Stored data SHALL never be altered except by a push to that location; entries SHALL be popped in push order.
REQ-027 All outputs SHALL be registered or decoded only from registered state, with no combinational path from any input to any output.

Reset
REQ-028 On an edge with Reset=1, the read pointer, write pointer, count and overflow SHALL be set to 0, giving out_valid=0, full=0, X_out=0 and Y_out=0.
REQ-029 Reset SHALL take priority over a simultaneous push, pop or clr_ovf, and SHALL discard all stored entries, including when asserted mid-stream.
REQ-030 Storage array contents SHALL NOT need to be reset.

Verification
REQ-031 Single pass-through: after reset, push (X_in=16'h1234, Y_in=16'hABCD) with rd_ready=0 -> from the next cycle, out_valid=1, X_out=16'h1234, Y_out=16'hABCD, count=1.
REQ-032 Fill and order: push 4 pairs (1,2),(3,4),(5,6),(7,8) with DEPTH=4 and rd_ready=0 -> full=1, count=4; then hold rd_ready=1 -> outputs 1,3,5,7 on X_out over 4 consecutive cycles, then out_valid=0 and X_out=0.
REQ-033 Overflow: with the FIFO full, push (16'hDEAD,16'hBEEF) with rd_ready=0 -> overflow=1, count=4, and the drained contents exclude 16'hDEAD; then clr_ovf=1 for one cycle -> overflow=0.
REQ-034 Simultaneous push/pop at full: with the FIFO full and rd_ready=1, push (16'h0F0F,16'h0000) -> count stays 4, overflow stays 0, and 16'h0F0F emerges as the 4th entry after the head.
REQ-035 Wrap-around: perform 10 alternating push/pop pairs with DEPTH=4 -> every popped value equals its pushed value and count returns to 0.
REQ-036 Reset mid-operation: with count=3, assert Reset together with data_in=1 and clr_ovf=1 -> next cycle count=0, out_valid=0, full=0, overflow=0, X_out=0.

Source files
------------

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through FIFO that buffers {X,Y} result pairs from the CORDIC core.
// Results arriving while the FIFO is full (and no pop happens) are dropped and flagged.
module cordic_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       data_in,
  input  logic [15:0]                X_in,
  input  logic [15:0]                Y_in,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  output logic [15:0]                X_out,
  output logic [15:0]                Y_out,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [31:0]   mem_q [DEPTH];

  logic          full_w, pop, push, drop;
  logic [31:0]   head;

  assign full_w = (count_q == CW'(DEPTH));
  assign pop    = (count_q != '0) && rd_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push   = data_in && (!full_w || pop);
  assign drop   = data_in && full_w && !pop;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: out_valid masks stale entries.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {X_in, Y_in};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign X_out     = out_valid ? head[31:16] : 16'h0000;
  assign Y_out     = out_valid ? head[15:0]  : 16'h0000;
  assign full      = full_w;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule
